// File: rtl/exec_pkg.sv
// rtl/exec_pkg.sv - shared encodings, FSM state type and defaults for the execute stage.
package exec_pkg;
  localparam int XLEN_DEF = 32;
  localparam int CTL_W    = 6;

  // ctl field bit positions: {strCtrl[2:0], MemtoReg, MemWrite, RegWrite}
  localparam int CTL_REGWRITE = 0;
  localparam int CTL_MEMWRITE = 1;
  localparam int CTL_MEMTOREG = 2;
  localparam int CTL_STR_LSB  = 3;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  localparam logic [1:0] SRCA_PC     = 2'b00;
  localparam logic [1:0] SRCA_ZERO_A = 2'b01;
  localparam logic [1:0] SRCA_ZERO_B = 2'b10;
  localparam logic [1:0] SRCA_R1     = 2'b11;

  localparam logic [1:0] SRCB_R2   = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;
  localparam logic [1:0] SRCB_ZERO = 2'b11;

  localparam logic [3:0] ALU_ADD   = 4'h0;
  localparam logic [3:0] ALU_SUB   = 4'h1;
  localparam logic [3:0] ALU_AND   = 4'h2;
  localparam logic [3:0] ALU_OR    = 4'h3;
  localparam logic [3:0] ALU_XOR   = 4'h4;
  localparam logic [3:0] ALU_SLL   = 4'h5;
  localparam logic [3:0] ALU_SRL   = 4'h6;
  localparam logic [3:0] ALU_SRA   = 4'h7;
  localparam logic [3:0] ALU_SLT   = 4'h8;
  localparam logic [3:0] ALU_SLTU  = 4'h9;
  localparam logic [3:0] ALU_SEQ   = 4'hA;
  localparam logic [3:0] ALU_SNE   = 4'hB;
  localparam logic [3:0] ALU_SGE   = 4'hC;
  localparam logic [3:0] ALU_SGEU  = 4'hD;
  localparam logic [3:0] ALU_PASSB = 4'hE;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_BUSY = 2'b01,
    MD_DONE = 2'b10
  } md_state_e;

  function automatic logic md_signed_a(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic md_signed_b(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction
endpackage

// File: rtl/alu.sv
// rtl/alu.sv - integer ALU; compare ops also drive the branch condition.
module alu
  import exec_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [3:0]      op_i,
  output logic [XLEN-1:0] result_o,
  output logic            branch_o
);
  localparam int SHW = $clog2(XLEN);

  logic cond;

  always_comb begin
    cond     = 1'b0;
    result_o = '0;
    case (op_i)
      ALU_SUB:   result_o = a_i - b_i;
      ALU_AND:   result_o = a_i & b_i;
      ALU_OR:    result_o = a_i | b_i;
      ALU_XOR:   result_o = a_i ^ b_i;
      ALU_SLL:   result_o = a_i << b_i[SHW-1:0];
      ALU_SRL:   result_o = a_i >> b_i[SHW-1:0];
      ALU_SRA:   result_o = $unsigned($signed(a_i) >>> b_i[SHW-1:0]);
      ALU_SLT:   cond = $signed(a_i) < $signed(b_i);
      ALU_SLTU:  cond = a_i < b_i;
      ALU_SEQ:   cond = a_i == b_i;
      ALU_SNE:   cond = a_i != b_i;
      ALU_SGE:   cond = $signed(a_i) >= $signed(b_i);
      ALU_SGEU:  cond = a_i >= b_i;
      ALU_PASSB: result_o = b_i;
      default:   result_o = a_i + b_i;
    endcase
    // Compare ops return their condition as a 0/1 result as well.
    if (op_i inside {ALU_SLT, ALU_SLTU, ALU_SEQ, ALU_SNE, ALU_SGE, ALU_SGEU})
      result_o = {{(XLEN-1){1'b0}}, cond};
    branch_o = cond;
  end
endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - fixed-latency iterative multiply/divide: shift-add multiply,
// restoring divide on operand magnitudes, sign correction in DONE.
module muldiv_unit
  import exec_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);
  localparam int CW = $clog2(XLEN + 1);

  md_state_e       state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [2:0]      op_q, op_d;
  logic            neg_q, neg_d, bzero_q, bzero_d;
  logic [XLEN-1:0] opnd_q, opnd_d, araw_q, araw_d, hi_q, hi_d, lo_q, lo_d;

  logic            a_neg, b_neg, div_ge;
  logic [XLEN-1:0] a_mag, b_mag, quo_s, rem_s;
  logic [XLEN:0]   mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] prod, prod_s;

  assign a_neg = md_signed_a(op_i) & a_i[XLEN-1];
  assign b_neg = md_signed_b(op_i) & b_i[XLEN-1];
  assign a_mag = a_neg ? -a_i : a_i;
  assign b_mag = b_neg ? -b_i : b_i;

  // opnd_q is the multiplicand for mul ops and the divisor for div ops.
  assign mul_sum   = {1'b0, hi_q} + ({1'b0, opnd_q} & {(XLEN+1){lo_q[0]}});
  assign div_shift = {hi_q, lo_q[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign div_ge    = ~div_diff[XLEN];

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    op_d    = op_q;
    neg_d   = neg_q;
    bzero_d = bzero_q;
    opnd_d  = opnd_q;
    araw_d  = araw_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      MD_IDLE: begin
        if (start_i && !flush_i) begin
          state_d = MD_BUSY;
          count_d = CW'(XLEN);
          op_d    = op_i;
          neg_d   = (op_i[2] && op_i[1]) ? a_neg : (a_neg ^ b_neg);
          bzero_d = (b_i == '0);
          araw_d  = a_i;
          opnd_d  = op_i[2] ? b_mag : a_mag;
          hi_d    = '0;
          lo_d    = op_i[2] ? a_mag : b_mag;
        end
      end
      MD_BUSY: begin
        count_d = count_q - CW'(1);
        if (op_q[2]) begin
          hi_d = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], div_ge};
        end else begin
          hi_d = mul_sum[XLEN:1];
          lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
        end
        if (count_q == CW'(1)) state_d = MD_DONE;
      end
      default: state_d = MD_IDLE;
    endcase
    if (flush_i) state_d = MD_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MD_IDLE;
      count_q <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      bzero_q <= 1'b0;
      opnd_q  <= '0;
      araw_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      bzero_q <= bzero_d;
      opnd_q  <= opnd_d;
      araw_q  <= araw_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign prod   = {hi_q, lo_q};
  assign prod_s = neg_q ? -prod : prod;
  assign quo_s  = neg_q ? -lo_q : lo_q;
  assign rem_s  = neg_q ? -hi_q : hi_q;
  assign done_o = (state_q == MD_DONE);

  always_comb begin
    result_o = '0;
    case (op_q)
      MD_MUL:                      result_o = prod_s[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: result_o = prod_s[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:             result_o = bzero_q ? '1 : quo_s;
      default:                     result_o = bzero_q ? araw_q : rem_s;
    endcase
  end
endmodule

// File: rtl/execute_md_stage.sv
// rtl/execute_md_stage.sv - execute stage with optional iterative mul/div and the E->M register.
// Define EXEC_MULDIV_EN to build in muldiv_unit; otherwise MdE/MdOpE are ignored.
module execute_md_stage
  import exec_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int RADDR = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CTL_W-1:0]  ctlE,
  input  logic              PCBranchE,
  input  logic [3:0]        ALUopE,
  input  logic [1:0]        SrcASelE,
  input  logic [1:0]        SrcBSelE,
  input  logic [XLEN-1:0]   immE,
  input  logic [XLEN-1:0]   PCE,
  input  logic [XLEN-1:0]   r1E,
  input  logic [XLEN-1:0]   r2E,
  input  logic [RADDR-1:0]  rdE,
  input  logic              MdE,
  input  logic [2:0]        MdOpE,
  input  logic              FlushE,
  output logic              StallE,
  output logic              PCsrcE,
  output logic [CTL_W-1:0]  ctlM,
  output logic [RADDR-1:0]  rdM,
  output logic [XLEN-1:0]   ALUoutM,
  output logic [XLEN-1:0]   PCplusImmM,
  output logic [XLEN-1:0]   r2M
);
  logic [XLEN-1:0]  src_a, src_b, alu_result, exe_result;
  logic             alu_branch, md_stall, pcsrc;
  logic [CTL_W-1:0] ctlM_q, ctlM_d;
  logic [RADDR-1:0] rdM_q, rdM_d;
  logic [XLEN-1:0]  ALUoutM_q, ALUoutM_d, PCplusImmM_q, PCplusImmM_d, r2M_q, r2M_d;

  always_comb begin
    src_a = '0;
    case (SrcASelE)
      SRCA_PC:                  src_a = PCE;
      SRCA_R1:                  src_a = r1E;
      SRCA_ZERO_A, SRCA_ZERO_B: src_a = '0;
      default:                  src_a = '0;
    endcase
    src_b = '0;
    case (SrcBSelE)
      SRCB_R2:   src_b = r2E;
      SRCB_IMM:  src_b = immE;
      SRCB_FOUR: src_b = XLEN'(4);
      default:   src_b = '0;
    endcase
  end

  alu #(.XLEN(XLEN)) u_alu (
    .a_i      (src_a),
    .b_i      (src_b),
    .op_i     (ALUopE),
    .result_o (alu_result),
    .branch_o (alu_branch)
  );

`ifdef EXEC_MULDIV_EN
  logic            md_done;
  logic [XLEN-1:0] md_result;

  muldiv_unit #(.XLEN(XLEN)) u_muldiv (
    .clk      (clk),
    .rst      (rst),
    .start_i  (MdE),
    .flush_i  (FlushE),
    .op_i     (MdOpE),
    .a_i      (r1E),
    .b_i      (r2E),
    .done_o   (md_done),
    .result_o (md_result)
  );

  assign md_stall   = MdE & ~md_done & ~FlushE;
  assign exe_result = MdE ? md_result : alu_result;
  assign pcsrc      = alu_branch & PCBranchE & ~MdE & ~FlushE;
`else
  logic md_unused;
  assign md_unused  = ^{MdE, MdOpE};
  assign md_stall   = 1'b0;
  assign exe_result = alu_result;
  assign pcsrc      = alu_branch & PCBranchE & ~FlushE;
`endif

  // Reset gates the handshakes so upstream never sees a stall or redirect mid-reset.
  assign StallE = md_stall & ~rst;
  assign PCsrcE = pcsrc & ~rst;

  assign ctlM_d       = (FlushE | md_stall) ? '0 : ctlE;
  assign rdM_d        = rdE;
  assign ALUoutM_d    = exe_result;
  assign PCplusImmM_d = PCE + immE;
  assign r2M_d        = r2E;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctlM_q       <= '0;
      rdM_q        <= '0;
      ALUoutM_q    <= '0;
      PCplusImmM_q <= '0;
      r2M_q        <= '0;
    end else begin
      ctlM_q       <= ctlM_d;
      rdM_q        <= rdM_d;
      ALUoutM_q    <= ALUoutM_d;
      PCplusImmM_q <= PCplusImmM_d;
      r2M_q        <= r2M_d;
    end
  end

  assign ctlM       = ctlM_q;
  assign rdM        = rdM_q;
  assign ALUoutM    = ALUoutM_q;
  assign PCplusImmM = PCplusImmM_q;
  assign r2M        = r2M_q;
endmodule

// File: tb/tb_execute_md_stage.sv
// tb/tb_execute_md_stage.sv - directed self-checking bench for execute_md_stage
// (mul/div steps are exercised when EXEC_MULDIV_EN is defined).
module tb_execute_md_stage;
  import exec_pkg::*;

  localparam int XLEN  = 32;
  localparam int RADDR = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic [5:0]       ctlE;
  logic             PCBranchE;
  logic [3:0]       ALUopE;
  logic [1:0]       SrcASelE, SrcBSelE;
  logic [XLEN-1:0]  immE, PCE, r1E, r2E;
  logic [RADDR-1:0] rdE;
  logic             MdE;
  logic [2:0]       MdOpE;
  logic             FlushE;
  logic             StallE, PCsrcE;
  logic [5:0]       ctlM;
  logic [RADDR-1:0] rdM;
  logic [XLEN-1:0]  ALUoutM, PCplusImmM, r2M;

  int checks = 0;
  int errors = 0;

  execute_md_stage #(.XLEN(XLEN), .RADDR(RADDR)) dut (
    .clk        (clk),
    .rst        (rst),
    .ctlE       (ctlE),
    .PCBranchE  (PCBranchE),
    .ALUopE     (ALUopE),
    .SrcASelE   (SrcASelE),
    .SrcBSelE   (SrcBSelE),
    .immE       (immE),
    .PCE        (PCE),
    .r1E        (r1E),
    .r2E        (r2E),
    .rdE        (rdE),
    .MdE        (MdE),
    .MdOpE      (MdOpE),
    .FlushE     (FlushE),
    .StallE     (StallE),
    .PCsrcE     (PCsrcE),
    .ctlM       (ctlM),
    .rdM        (rdM),
    .ALUoutM    (ALUoutM),
    .PCplusImmM (PCplusImmM),
    .r2M        (r2M)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alu(input logic [3:0] op, input logic [1:0] asel, input logic [1:0] bsel,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
    ALUopE = op; SrcASelE = asel; SrcBSelE = bsel;
    r1E = a; r2E = b; immE = imm;
    MdE = 1'b0; FlushE = 1'b0; PCBranchE = 1'b0;
  endtask

`ifdef EXEC_MULDIV_EN
  task automatic md_run(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int   n;
    logic bubble_ok;
    MdE = 1'b1; MdOpE = op; r1E = a; r2E = b;
    ctlE = 6'b000001; rdE = 5'd7; FlushE = 1'b0; PCBranchE = 1'b0;
    n = 0;
    bubble_ok = 1'b1;
    #1;
    while (StallE === 1'b1 && n < 100) begin
      n++;
      tick();
      if (ctlM !== 6'd0) bubble_ok = 1'b0;
      #1;
    end
    chk({tag, " stall_cycles"}, 32'(n), 32'd33);
    chk({tag, " bubble"}, {31'd0, bubble_ok}, 32'd1);
    tick();
    chk({tag, " result"}, ALUoutM, exp);
    chk({tag, " ctlM"}, {26'd0, ctlM}, 32'd1);
    MdE = 1'b0;
  endtask
`endif

  initial begin
    // Reset with inputs that would stall and redirect if reset did not gate them.
    rst = 1'b1;
    ctlE = 6'b111111; rdE = 5'd31; PCE = 32'h40; MdOpE = MD_MUL;
    set_alu(ALU_SEQ, SRCA_ZERO_A, SRCB_ZERO, 32'h1, 32'h2, 32'h3);
    MdE = 1'b1; PCBranchE = 1'b1;
    tick();
    chk("reset StallE", {31'd0, StallE}, 32'd0);
    chk("reset PCsrcE", {31'd0, PCsrcE}, 32'd0);
    chk("reset ctlM", {26'd0, ctlM}, 32'd0);
    chk("reset rdM", {27'd0, rdM}, 32'd0);
    chk("reset ALUoutM", ALUoutM, 32'd0);
    chk("reset PCplusImmM", PCplusImmM, 32'd0);
    chk("reset r2M", r2M, 32'd0);

    rst = 1'b0; MdE = 1'b0;
    #1;
    chk("seq branch taken", {31'd0, PCsrcE}, 32'd1);

    // ADD r1 + imm
    set_alu(ALU_ADD, SRCA_R1, SRCB_IMM, 32'd5, 32'h55, 32'd7);
    ctlE = 6'b001101; rdE = 5'd3; PCE = 32'h100;
    #1;
    chk("add StallE", {31'd0, StallE}, 32'd0);
    tick();
    chk("add ALUoutM", ALUoutM, 32'd12);
    chk("add ctlM", {26'd0, ctlM}, 32'h0D);
    chk("add rdM", {27'd0, rdM}, 32'd3);
    chk("add PCplusImmM", PCplusImmM, 32'h107);
    chk("add r2M", r2M, 32'h55);

    // zero - 4 via SrcASel 10 and SrcBSel 10
    set_alu(ALU_SUB, SRCA_ZERO_B, SRCB_FOUR, 32'h1234, 32'h0, 32'h0);
    tick();
    chk("sub zero-four", ALUoutM, 32'hFFFF_FFFC);

    // PC + zero
    set_alu(ALU_ADD, SRCA_PC, SRCB_ZERO, 32'h1, 32'h2, 32'h3);
    PCE = 32'h200;
    tick();
    chk("pc pass", ALUoutM, 32'h200);

    // signed compare branch, then killed by flush
    set_alu(ALU_SLT, SRCA_R1, SRCB_R2, 32'hFFFF_FFFD, 32'd2, 32'd0);
    PCBranchE = 1'b1;
    #1;
    chk("slt branch", {31'd0, PCsrcE}, 32'd1);
    FlushE = 1'b1;
    #1;
    chk("flushed branch", {31'd0, PCsrcE}, 32'd0);
    tick();
    chk("flush bubble ctlM", {26'd0, ctlM}, 32'd0);
    FlushE = 1'b0; PCBranchE = 1'b0;

`ifdef EXEC_MULDIV_EN
    md_run("mulhu", MD_MULHU, 32'hFFFF_FFFF, 32'd3, 32'h0000_0002);
    md_run("mul", MD_MUL, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD);
    md_run("mulh", MD_MULH, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF);
    md_run("mulhsu", MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    md_run("divu by0", MD_DIVU, 32'd100, 32'd0, 32'hFFFF_FFFF);
    md_run("remu by0", MD_REMU, 32'd100, 32'd0, 32'd100);
    md_run("div by0", MD_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF);
    md_run("rem by0", MD_REM, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9);
    md_run("div -7/2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    md_run("rem -7/2", MD_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    md_run("div ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    md_run("rem ovf", MD_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    md_run("divu", MD_DIVU, 32'd100, 32'd7, 32'd14);

    // flush in BUSY cycle 10, then an ADD and a full-length MUL
    MdE = 1'b1; MdOpE = MD_MUL; r1E = 32'd6; r2E = 32'd7; ctlE = 6'b000001;
    for (int i = 0; i < 10; i++) tick();
    FlushE = 1'b1;
    #1;
    chk("flush StallE", {31'd0, StallE}, 32'd0);
    tick();
    set_alu(ALU_ADD, SRCA_R1, SRCB_IMM, 32'd20, 32'd0, 32'd22);
    ctlE = 6'b000101;
    #1;
    chk("post-flush ctlM", {26'd0, ctlM}, 32'd0);
    chk("post-flush StallE", {31'd0, StallE}, 32'd0);
    tick();
    chk("post-flush add", ALUoutM, 32'd42);
    chk("post-flush add ctlM", {26'd0, ctlM}, 32'h05);
    md_run("mul after flush", MD_MUL, 32'd6, 32'd7, 32'd42);

    // reset in BUSY cycle 5 with MdE still asserted
    MdE = 1'b1; MdOpE = MD_DIVU; r1E = 32'd100; r2E = 32'd3; rdE = 5'd9;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    #1;
    chk("midop rst StallE", {31'd0, StallE}, 32'd0);
    chk("midop rst ALUoutM", ALUoutM, 32'd0);
    chk("midop rst rdM", {27'd0, rdM}, 32'd0);
    chk("midop rst PCplusImmM", PCplusImmM, 32'd0);
    chk("midop rst r2M", r2M, 32'd0);
    chk("midop rst ctlM", {26'd0, ctlM}, 32'd0);
    tick();
    rst = 1'b0; MdE = 1'b0;
    tick();
    md_run("mul after reset", MD_MUL, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD);
`else
    // MdE/MdOpE must be ignored: the op runs as ALUopE with no stall
    set_alu(ALU_ADD, SRCA_R1, SRCB_IMM, 32'd5, 32'd0, 32'd7);
    MdE = 1'b1; MdOpE = MD_DIV; ctlE = 6'b000001;
    #1;
    chk("md ignored StallE", {31'd0, StallE}, 32'd0);
    tick();
    chk("md ignored result", ALUoutM, 32'd12);
    chk("md ignored ctlM", {26'd0, ctlM}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst ALUoutM", ALUoutM, 32'd0);
    chk("rst ctlM", {26'd0, ctlM}, 32'd0);
    tick();
    rst = 1'b0; MdE = 1'b0;
    set_alu(ALU_XOR, SRCA_R1, SRCB_R2, 32'hF0F0_0000, 32'h0FF0_0001, 32'd0);
    tick();
    chk("xor after reset", ALUoutM, 32'hFF00_0001);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/execute_md_stage.md
# execute_md_stage

Parametrised successor of the pipeline execute stage. Adds an iterative multiply/divide unit (RV M-extension ops), stall and flush handshakes, and configurable datapath width. It sits between the decode/register-read pipeline register and the memory stage. It owns the E→M pipeline register.

## Interface
- XLEN, 32, datapath width (≥8, even)
- RADDR, 5, register-address width
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- ctlE  in  6  {strCtrl[2:0], MemtoReg, MemWrite, RegWrite} of the E instruction
- PCBranchE  in  1  instruction is a conditional branch
- ALUopE  in  4  ALU operation code (existing alu encoding)
- SrcASelE  in  2  00 PC, 01 zero, 10 zero, 11 r1
- SrcBSelE  in  2  00 r2, 01 imm, 10 constant 4, 11 zero
- immE, PCE, r1E, r2E  in  XLEN each  immediate, PC, rs1 value, rs2 value
- rdE  in  RADDR  destination register
- MdE  in  1  instruction is a mul/div op; overrides ALUopE
- MdOpE  in  3  funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
- FlushE  in  1  kill the E instruction
- StallE  out  1  hold F/D/E; upstream keeps all E inputs stable while high
- PCsrcE  out  1  branch taken = alu branch & PCBranchE & !MdE & !FlushE
- ctlM  out  6  registered ctlE, or a bubble
- rdM  out  RADDR  registered rdE
- ALUoutM, PCplusImmM, r2M  out  XLEN each  registered result, PCE+immE (mod 2^XLEN), r2E

## Operation
- Non-Md ops: srcA/srcB are muxed per the Sel codes, the existing alu computes the result, and it is registered to M at the next edge. SrcASel 10 yields zero and is never high-Z.
- Md FSM states: IDLE → BUSY → DONE → IDLE.
  - IDLE with MdE & !FlushE: latch operand magnitudes and sign flags, load count=XLEN, go to BUSY.
  - BUSY: one shift-add (mul) or restoring-subtract (div) step per cycle, count-1. Go to DONE when count reaches 0.
  - DONE: apply sign correction, present the result, go to IDLE.
- MUL returns the low XLEN bits of the product. MULH, MULHSU and MULHU return the high XLEN bits with signed×signed, signed×unsigned and unsigned×unsigned operands respectively.
- Divide by zero: quotient = all ones, remainder = dividend, for both signed and unsigned ops.
- Signed overflow (−2^(XLEN−1) / −1): quotient = dividend, remainder = 0.
- Latency is fixed for every operand value; there is no early-out.
- StallE = MdE & (state≠DONE) & !FlushE.
- While StallE is high the M register loads a bubble: ctlM=0 and other M fields don't-care.
- FlushE: in any state, returns the FSM to IDLE at the next edge and loads a bubble into M.

## Timing
- All M outputs reset to 0. StallE and PCsrcE are 0 during reset. FSM resets to IDLE and count to 0.
- Non-Md op: result appears on M outputs 1 cycle after presentation.
- Md op: occupies E for XLEN+2 cycles (cycle 0 IDLE, cycles 1..XLEN BUSY, cycle XLEN+1 DONE with StallE=0). The result is on ALUoutM after the edge ending DONE.
- A new MdE may be accepted in the cycle immediately after DONE.
- Reset mid-operation aborts immediately. No result is ever written.
- If FlushE and MdE are high simultaneously in IDLE, the FSM does not start.

## Configuration
- EXEC_MULDIV_EN defined: muldiv_unit is instantiated and behaves as above.
- EXEC_MULDIV_EN undefined: muldiv_unit is removed, MdE and MdOpE are ignored (the op executes as ALUopE), StallE is tied to 0, and all ops have 1-cycle latency.

## Structure
- exec_pkg holds:
  - XLEN default
  - MdOp funct3 encodings
  - SrcASel and SrcBSel encodings
  - FSM state typedef (IDLE/BUSY/DONE)
  - ctl field bit positions
- Sub-module muldiv_unit contains the FSM, counter and iterative datapath, with start/flush/done/result ports. The top level holds the muxes, the alu instance and the pipeline register.

## Test plan
- ADD: SrcASel=11, r1=5, SrcBSel=01, imm=7 → ALUoutM=12 after 1 edge, StallE never high.
- MULHU 0xFFFFFFFF×3 (XLEN=32) → StallE high 33 cycles with ctlM=0 throughout, then ALUoutM=0x00000002. MUL on the same operands → 0xFFFFFFFD.
- DIVU 100/0 → 0xFFFFFFFF. REMU 100/0 → 100. DIV −7/2 → −3. REM −7/2 → −1.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM on the same operands → 0.
- FlushE asserted in BUSY cycle 10 → StallE=0 next cycle, ctlM=0, and a following ADD completes normally.
- rst asserted in BUSY cycle 5 → all M outputs 0 and StallE=0 immediately. A new MUL after reset gives a correct result.
